// File: rtl/rainbow_rom_arbiter.sv
// Round-robin arbiter that shares the single-port rainbow colour ROM between two
// pixel requesters. It also tracks in-flight reads and returns each colour to the requester that issued it.
module rainbow_rom_arbiter #(
    parameter int unsigned ROM_LATENCY = 2,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              lock0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              lock1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    logic                   prio_q, prio_d;
    logic [ADDR_W-1:0]      rom_addr_q, rom_addr_d;
    logic [ROM_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [ROM_LATENCY-1:0] tag_id_q, tag_id_d;
    logic                   rvalid0_q, rvalid0_d;
    logic                   rvalid1_q, rvalid1_d;
    logic                   issue;

    // Grant: a lone requester always wins; on a conflict prio decides.
    always_comb begin
        gnt0 = req0 & (~req1 | ~prio_q);
        gnt1 = req1 & (~req0 | prio_q);
    end

    assign issue = gnt0 | gnt1;

    // A locked grant keeps priority with the winner; otherwise it passes to the other requester.
    always_comb begin
        prio_d     = prio_q;
        rom_addr_d = rom_addr_q;
        if (gnt0) begin
            prio_d     = ~lock0;
            rom_addr_d = addr0;
        end else if (gnt1) begin
            prio_d     = lock1;
            rom_addr_d = addr1;
        end
    end

    // The tag shift register mirrors the ROM pipeline. Its last stage is kept as a one-hot return strobe.
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = issue;
        tag_id_d[0]  = gnt1;
        for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
        rvalid0_d = tag_vld_q[ROM_LATENCY-1] & ~tag_id_q[ROM_LATENCY-1];
        rvalid1_d = tag_vld_q[ROM_LATENCY-1] & tag_id_q[ROM_LATENCY-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q     <= 1'b0;
            rom_addr_q <= '0;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            rom_addr_q <= rom_addr_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata    = rom_data;

endmodule

// File: tb/tb_rainbow_rom_arbiter.sv
// Bench for rainbow_rom_arbiter: it provides a 2-cycle ROM and a queue-based reference model checked every cycle.
// It adds table vectors for arbitration and directed sequences for the return path.
module tb_rainbow_rom_arbiter;
    localparam int unsigned AW  = 7;
    localparam int unsigned DW  = 12;
    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata, rom_data;
    logic [AW-1:0] rom_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rainbow_rom_arbiter #(.ROM_LATENCY(LAT), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .lock0(lock0), .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .addr1(addr1), .lock1(lock1), .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    // Rainbow ROM contents: a few known colours; other addresses in range use a fill pattern; out-of-range addresses return the default colour.
    function automatic logic [DW-1:0] colour(input logic [AW-1:0] a);
        case (a)
            7'd24:   return 12'hF00;
            7'd25:   return 12'hE10;
            7'd26:   return 12'hE30;
            7'd30:   return 12'hC82;
            7'd40:   return 12'h7E7;
            default: begin
                if (a >= 7'd24 && a <= 7'd55) return {a[3:0], ~a[3:0], a[6:3]};
                return 12'h00F;
            end
        endcase
    endfunction

    logic [DW-1:0] rom_p1, rom_p2;
    always @(posedge clk) begin
        rom_p1 <= colour(rom_addr);
        rom_p2 <= rom_p1;
    end
    assign rom_data = rom_p2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: each grant schedules a return LAT+1 cycles later in a FIFO.
    typedef struct {
        int            due;
        bit            id;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          pend[$];
    bit            m_prio = 1'b0;
    logic [AW-1:0] m_addr = '0;
    int            cyc    = 0;

    always @(negedge clk) begin : model
        bit   g0, g1, e0, e1;
        ret_t r;
        if (reset) begin
            pend.delete();
            m_prio = 1'b0;
            m_addr = '0;
            check("rst_rvalid0", 32'(rvalid0), 32'd0);
            check("rst_rvalid1", 32'(rvalid1), 32'd0);
            check("rst_rom_addr", 32'(rom_addr), 32'd0);
        end else begin
            if (req0 && req1) begin
                g0 = !m_prio;
                g1 = m_prio;
            end else begin
                g0 = req0;
                g1 = req1;
            end
            check("mdl_gnt0", 32'(gnt0), 32'(g0));
            check("mdl_gnt1", 32'(gnt1), 32'(g1));
            check("mdl_rom_addr", 32'(rom_addr), 32'(m_addr));
            e0 = 1'b0;
            e1 = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                r = pend.pop_front();
                if (r.id) e1 = 1'b1; else e0 = 1'b1;
                check("mdl_rdata", 32'(rdata), 32'(r.data));
            end
            check("mdl_rvalid0", 32'(rvalid0), 32'(e0));
            check("mdl_rvalid1", 32'(rvalid1), 32'(e1));
            if (g0 || g1) begin
                r.due  = cyc + int'(LAT) + 1;
                r.id   = g1;
                r.data = colour(g1 ? addr1 : addr0);
                m_addr = g1 ? addr1 : addr0;
                m_prio = g1 ? lock1 : !lock0;
                pend.push_back(r);
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic [AW-1:0] a0, input logic l0,
                         input logic r1, input logic [AW-1:0] a1, input logic l1);
        req0 = r0; addr0 = a0; lock0 = l0;
        req1 = r1; addr1 = a1; lock1 = l1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        repeat (n) step();
    endtask

    typedef struct {
        logic          r0, r1, l0, l1;
        logic [AW-1:0] a0, a1;
        logic          g0, g1;
    } vec_t;

    vec_t          vecs[12];
    logic [DW-1:0] exp_seq[3];
    bit            held0, held1;

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("post_rst_rom_addr", 32'(rom_addr), 32'd0);
        check("post_rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);

        // Arbitration vectors starting with priority at requester 0.
        vecs[0]  = '{1, 1, 0, 0, 7'd30, 7'd40, 1, 0};
        vecs[1]  = '{1, 1, 0, 0, 7'd30, 7'd40, 0, 1};
        vecs[2]  = '{0, 1, 0, 0, 7'd31, 7'd41, 0, 1};
        vecs[3]  = '{1, 1, 0, 0, 7'd32, 7'd42, 1, 0};
        vecs[4]  = '{1, 0, 1, 0, 7'd33, 7'd42, 1, 0};
        vecs[5]  = '{1, 1, 0, 0, 7'd34, 7'd42, 1, 0};
        vecs[6]  = '{1, 1, 0, 1, 7'd35, 7'd42, 0, 1};
        vecs[7]  = '{1, 1, 0, 1, 7'd35, 7'd43, 0, 1};
        vecs[8]  = '{1, 1, 0, 0, 7'd35, 7'd44, 0, 1};
        vecs[9]  = '{0, 0, 0, 0, 7'd35, 7'd44, 0, 0};
        vecs[10] = '{1, 1, 0, 1, 7'd0,  7'd127, 1, 0};
        vecs[11] = '{1, 1, 0, 0, 7'd1,  7'd127, 0, 1};
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].r0, vecs[i].a0, vecs[i].l0, vecs[i].r1, vecs[i].a1, vecs[i].l1);
            #1;
            check($sformatf("vec%0d_gnt0", i), 32'(gnt0), 32'(vecs[i].g0));
            check($sformatf("vec%0d_gnt1", i), 32'(gnt1), 32'(vecs[i].g1));
            step();
        end
        idle(5);

        // Single read at address 24.
        drive(1'b1, 7'd24, 1'b0, 1'b0, '0, 1'b0);
        #1 check("t2_gnt0", 32'(gnt0), 32'd1);
        step();
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        #1 check("t2_rom_addr", 32'(rom_addr), 32'd24);
        step();
        step();
        check("t2_rvalid0", 32'(rvalid0), 32'd1);
        check("t2_rvalid1", 32'(rvalid1), 32'd0);
        check("t2_rdata", 32'(rdata), 32'hF00);
        idle(3);

        // Back-to-back reads from requester 0.
        exp_seq[0] = 12'hF00; exp_seq[1] = 12'hE10; exp_seq[2] = 12'hE30;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive(1'b1, 7'(24 + i), 1'b0, 1'b0, '0, 1'b0);
            else       drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
            #1;
            if (i >= 3) begin
                check("t5_rvalid0", 32'(rvalid0), 32'd1);
                check("t5_rdata", 32'(rdata), 32'(exp_seq[i-3]));
            end
            step();
        end
        idle(2);

        // Out-of-range addresses return the default colour.
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      drive(1'b0, '0, 1'b0, 1'b1, 7'd0, 1'b0);
            else if (i == 1) drive(1'b0, '0, 1'b0, 1'b1, 7'd127, 1'b0);
            else             drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
            #1;
            if (i >= 3) begin
                check("t6_rvalid1", 32'(rvalid1), 32'd1);
                check("t6_rdata", 32'(rdata), 32'h00F);
            end
            step();
        end
        idle(3);

        // Random traffic that follows the requester hold contract.
        held0 = 1'b0;
        held1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!(held0 && $urandom_range(0, 9) != 0)) begin
                req0  = 1'($urandom_range(0, 2) != 0);
                addr0 = 7'($urandom);
            end
            if (!(held1 && $urandom_range(0, 9) != 0)) begin
                req1  = 1'($urandom_range(0, 2) != 0);
                addr1 = 7'($urandom);
            end
            lock0 = 1'($urandom_range(0, 3) == 0);
            lock1 = 1'($urandom_range(0, 3) == 0);
            #1;
            held0 = req0 && !gnt0;
            held1 = req1 && !gnt1;
            step();
        end

        // Mid-stream reset while reads are in flight.
        drive(1'b1, 7'd50, 1'b0, 1'b1, 7'd51, 1'b0);
        step();
        drive(1'b1, 7'd52, 1'b0, 1'b1, 7'd53, 1'b0);
        #1 reset = 1'b1;
        #1;
        check("t1_rom_addr", 32'(rom_addr), 32'd0);
        check("t1_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        step();
        reset = 1'b0;

        // Both requesters held: alternating grants starting with requester 0.
        for (int i = 0; i < 8; i++) begin
            if (i < 4) drive(1'b1, 7'd30, 1'b0, 1'b1, 7'd40, 1'b0);
            else       drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
            #1;
            if (i < 4) check("t3_gnt0", 32'(gnt0), 32'(i % 2 == 0));
            if (i < 3) check("t3_no_early_ret", 32'({rvalid1, rvalid0}), 32'd0);
            if (i >= 3 && i < 7) begin
                check("t3_rvalid0", 32'(rvalid0), 32'((i - 3) % 2 == 0));
                check("t3_rdata", 32'(rdata), ((i - 3) % 2 == 0) ? 32'hC82 : 32'h7E7);
            end
            step();
        end
        idle(2);

        // Lock0 over three grants keeps requester 0 for four cycles.
        for (int i = 0; i < 9; i++) begin
            if (i < 5) drive(1'b1, 7'(24 + i), 1'(i < 3), 1'b1, 7'd40, 1'b0);
            else       drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
            #1;
            if (i < 5) check("t4_gnt0", 32'(gnt0), 32'(i < 4));
            if (i >= 3 && i < 8) begin
                check("t4_rvalid0", 32'(rvalid0), 32'(i < 7));
                check("t4_rvalid1", 32'(rvalid1), 32'(i == 7));
            end
            step();
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rainbow_rom_arbiter.md
Name: rainbow_rom_arbiter

Overview:
Shares the single-port rainbow colour ROM (7-bit address, 12-bit colour, 2-cycle read latency) between two pixel-pipeline requesters. It uses round-robin arbitration with an optional lock for burst reads. The block registers the winning address into the ROM and tracks in-flight reads in a tag pipeline. It returns each colour word to the requester that issued it, with a per-requester valid strobe.

Parameters:
ROM_LATENCY, 2, cycles from ROM address register input to valid ROM data output.
ADDR_W, 7, ROM address width.
DATA_W, 12, colour word width (4:4:4 RGB).

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
req0  input  1  requester 0 read request.
addr0  input  ADDR_W  requester 0 ROM address.
lock0  input  1  requester 0 keeps priority after this grant.
gnt0  output  1  requester 0 granted this cycle (combinational).
rvalid0  output  1  rdata holds requester 0's result this cycle.
req1  input  1  requester 1 read request.
addr1  input  ADDR_W  requester 1 ROM address.
lock1  input  1  requester 1 keeps priority after this grant.
gnt1  output  1  requester 1 granted this cycle (combinational).
rvalid1  output  1  rdata holds requester 1's result this cycle.
rdata  output  DATA_W  returned colour word, shared by both requesters.
rom_addr  output  ADDR_W  registered address to ROM.
rom_data  input  DATA_W  ROM data output.

Behaviour:
- Reset (async, immediate):
  - rom_addr=0.
  - Tag pipeline cleared, so rvalid0=rvalid1=0.
  - prio=0 (requester 0 wins the first conflict).
  - All in-flight reads are dropped and never returned.
- Arbitration (combinational, cycle T):
  - Only req0 → gnt0=1.
  - Only req1 → gnt1=1.
  - Both → grant goes to prio.
  - Neither → no grant.
  - At most one gnt is high. gnt is never high without its req.
- Priority update (edge ending T, only if a grant occurred):
  - Granted X with lockX=1 → prio=X.
  - Granted X with lockX=0 → prio=other requester.
  - No grant → prio unchanged.
- Issue (edge ending T, granted X):
  - rom_addr <= addrX.
  - Tag pipeline stage 0 <= {valid=1, id=X}.
  - No grant → rom_addr holds its value; stage 0 valid=0.
- Tag pipeline:
  - Depth ROM_LATENCY+1, shifts every cycle, no stalls.
  - Throughput is one read per cycle.
- Return:
  - Final stage valid with id=X → rvalidX=1 in cycle T+1+ROM_LATENCY (T+3 at default).
  - rdata=rom_data (combinational pass-through), valid only while an rvalid is high.
  - rvalid0 and rvalid1 are never both high.
- Requester contract:
  - addrX and lockX are sampled only in the grant cycle.
  - A requester that is not granted keeps req high and addr stable until granted.
  - Dropping req before grant withdraws the request, with no side effects.
- Addresses are passed unmodified. Out-of-range values (outside 24..55) return the ROM default colour 12'h00F.
- Lock held continuously with req → that requester is granted every cycle (starvation of the other is the caller's responsibility).
- Lock asserted by a requester that is not granted has no effect.

Test Plan:
1. Assert reset mid-stream → rom_addr=0, rvalid0=rvalid1=0 within the same cycle. After release, simultaneous req0/req1 grant requester 0 first.
2. req0 only, addr0=24, in cycle T → gnt0=1 in T, rom_addr=24 in T+1, rvalid0=1 and rdata=12'hF00 in T+3, rvalid1=0 throughout.
3. req0 and req1 both held with addr0=30 and addr1=40, no lock → grants alternate 0,1,0,1. rvalid alternates three cycles later with rdata 12'hC82 and 12'h7E7.
4. Both requesting, lock0=1 for three grants then 0 → gnt0 for four consecutive cycles (three locked grants plus the final unlocked one), then gnt1. Returns are in issue order.
5. req0 back-to-back with addr0=24,25,26 → rvalid0 high three consecutive cycles with rdata F00, E10, E30.
6. req1 with addr1=0 and addr1=127 → rvalid1 with rdata=12'h00F for each.
